multi_chan_data_sync: RTL and testbench
=======================================

// Module: multi_chan_data_sync
// PURPOSE
//  Multi-channel, parametrised multi-cycle-path (MCP) data synchroniser for the destination clock domain.
//  Per channel: a source-domain qualifier (bus_enable) is synchronised through an N-flop chain and
//  edge-detected; the qualifier edge captures the source bus into a holding register.
//  Each channel then presents the captured word on a valid/ready port and returns an ack toggle to the
//  source domain. It also flags overflow when a new word arrives before the old one is consumed.
//  Sits at every CDC boundary carrying multi-bit register or config traffic into CLK.
// PARAMETERS
//  BUS_WIDTH   8  data bits per channel
//  NUM_STAGES  2  synchroniser flops on bus_enable (legal 2..4)
//  NUM_CH      1  number of independent channels (legal 1..16)
//  EDGE_MODE   0  0 = LEVEL: event on rising edge of synced enable; 1 = TOGGLE: event on either edge
// PORTS
//  CLK           in   1                  destination clock
//  RST           in   1                  async active-low reset
//  unsync_bus    in   NUM_CH*BUS_WIDTH   source data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH]
//  bus_enable    in   NUM_CH             source qualifier per channel (level or toggle, per EDGE_MODE)
//  out_ready     in   NUM_CH             consumer accepts sync_bus of channel c this cycle
//  ovf_clr       in   NUM_CH             one-cycle pulse; clears overflow[c]
//  sync_bus      out  NUM_CH*BUS_WIDTH   captured data, registered
//  out_valid     out  NUM_CH             holding register of channel c is full
//  enable_pulse  out  NUM_CH             registered 1-cycle pulse on every capture
//  ack_tgl       out  NUM_CH             toggles on each consume (valid & ready); source syncs it back
//  overflow      out  NUM_CH             sticky: event arrived while full and not consumed
// BEHAVIOUR
//  - Reset (RST = 0, async): sync chain, edge-detect flop, sync_bus, out_valid, enable_pulse, ack_tgl
//    and overflow all go to 0. The source must reset its qualifier to 0 as well.
//    A qualifier still at 1 after reset release is seen as an event; this is intended.
//  - Event detection (event = combinational, from the last sync stage s and its delayed copy p):
//    EDGE_MODE = 0: event = s & ~p.  EDGE_MODE = 1: event = s ^ p.
//  - Latency: qualifier changes before CLK edge k -> sync_bus/out_valid/enable_pulse update at
//    edge k+NUM_STAGES (capture occurs on the edge following event).
//  - Source contract: unsync_bus[c] is held stable from the qualifier change until ack_tgl[c] is seen
//    toggled in the source domain. The bus itself is never synchronised.
//  - Per channel, on each edge:
//    - event & (~out_valid | out_ready): capture bus, out_valid <= 1, enable_pulse <= 1.
//    - event & out_valid & ~out_ready: word dropped, holding register and out_valid unchanged,
//      overflow <= 1, enable_pulse <= 0.
//    - ~event & out_valid & out_ready: out_valid <= 0, sync_bus keeps its last value.
//    - valid & ready always toggles ack_tgl, including when a capture happens in the same cycle.
//      In that case out_valid stays 1 and the new word is visible next cycle.
//    - ovf_clr and a new overflow in the same cycle: set wins, overflow stays 1.
//  - Channels are fully independent; no arbitration, no shared state.
//  - Only bus_enable is a CDC input. out_ready and ovf_clr are CLK-domain.
// STRUCTURE
//  - Package mcp_sync_pkg: localparams EDGE_LEVEL = 0, EDGE_TOGGLE = 1; MIN_STAGES = 2, MAX_STAGES = 4.
//  - Sub-module mcp_sync_chan: one complete channel, containing the sync chain, edge detect,
//    holding register, valid/ack/overflow logic.
//  - Top level: a generate loop over NUM_CH instances of mcp_sync_chan plus bus slicing.
//  - Elaboration-time check: NUM_STAGES must lie within MIN..MAX.
// TESTING
//  1. LEVEL, NS=2, 1 ch: bus=8'hA5, enable 0->1 before edge 0, ready=1.
//     -> sync_bus=8'hA5, out_valid=1 and enable_pulse=1 at edge 2; enable_pulse=0 at edge 3.
//  2. TOGGLE, NS=3: enable toggles 0->1 then 1->0, with bus 8'h11 then 8'h22, ready=1.
//     -> two captures, each 3 edges after its toggle; ack_tgl ends at 0 after two toggles.
//  3. Backpressure: ready=0, two events carrying 8'h33 then 8'h44.
//     -> sync_bus=8'h33, overflow=1. ovf_clr pulse -> overflow=0. ready=1 -> out_valid=0, ack_tgl toggles.
//  4. Simultaneous: valid=1 with 8'h55, ready=1 on the same edge as an event carrying 8'h66.
//     -> out_valid stays 1, sync_bus=8'h66, ack_tgl toggles once, overflow=0.
//  5. Reset mid-operation: RST low while out_valid=1 and the chain is mid-transition.
//     -> all outputs 0 immediately (async). After release with enable=1 (LEVEL mode),
//        exactly one capture occurs NS edges later.
//  6. NUM_CH=4: staggered events on ch0 and ch3, ready held low on ch3 only.
//     -> ch0 flows normally; only overflow[3] sets; ch1 and ch2 outputs stay 0.

Source files
------------

// File: rtl/mcp_sync_pkg.sv
// Shared constants for the multi-channel MCP data synchroniser.
package mcp_sync_pkg;

    // Qualifier interpretation
    localparam int EDGE_LEVEL  = 0;
    localparam int EDGE_TOGGLE = 1;

    // Legal depth of the qualifier synchroniser chain
    localparam int MIN_STAGES = 2;
    localparam int MAX_STAGES = 4;

    // Legal channel count
    localparam int MIN_CH = 1;
    localparam int MAX_CH = 16;

endpackage

// File: rtl/multi_chan_data_sync_if.sv
// Bundle of the per-channel data/handshake vectors crossing into the CLK domain.
// master: source + consumer side; slave: the synchroniser.
interface multi_chan_data_sync_if #(
    parameter int NUM_CH    = 1,
    parameter int BUS_WIDTH = 8
);
    logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus;
    logic [NUM_CH-1:0]           bus_enable;
    logic [NUM_CH-1:0]           out_ready;
    logic [NUM_CH-1:0]           ovf_clr;
    logic [NUM_CH*BUS_WIDTH-1:0] sync_bus;
    logic [NUM_CH-1:0]           out_valid;
    logic [NUM_CH-1:0]           enable_pulse;
    logic [NUM_CH-1:0]           ack_tgl;
    logic [NUM_CH-1:0]           overflow;

    modport master (
        output unsync_bus, bus_enable, out_ready, ovf_clr,
        input  sync_bus, out_valid, enable_pulse, ack_tgl, overflow
    );

    modport slave (
        input  unsync_bus, bus_enable, out_ready, ovf_clr,
        output sync_bus, out_valid, enable_pulse, ack_tgl, overflow
    );
endinterface

// File: rtl/mcp_sync_chan.sv
// One MCP synchroniser channel: qualifier sync chain, edge detect,
// holding register with valid/ready output, ack toggle and sticky overflow.
// The data bus is never synchronised; it is sampled only when the
// synchronised qualifier says it has been stable for NUM_STAGES cycles.
module mcp_sync_chan
    import mcp_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int EDGE_MODE  = EDGE_LEVEL
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    input  logic                 out_ready,
    input  logic                 ovf_clr,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 out_valid,
    output logic                 enable_pulse,
    output logic                 ack_tgl,
    output logic                 overflow
);

    logic [NUM_STAGES-1:0] sync_q;
    logic                  sync_dly;
    logic                  evt;
    logic                  consume;
    logic                  capture;
    logic                  drop;

    // Level mode reacts to a rising qualifier only; toggle mode to any change.
    function automatic logic detect_event(input logic s, input logic p);
        if (EDGE_MODE == EDGE_TOGGLE)
            return s ^ p;
        else
            return s & ~p;
    endfunction

    // Qualifier synchroniser chain; bit 0 is the metastability-exposed flop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            sync_q <= '0;
        else
            sync_q <= {sync_q[NUM_STAGES-2:0], bus_enable};
    end

    // Delayed copy of the last sync stage for edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            sync_dly <= 1'b0;
        else
            sync_dly <= sync_q[NUM_STAGES-1];
    end

    assign evt     = detect_event(sync_q[NUM_STAGES-1], sync_dly);
    assign consume = out_valid & out_ready;
    // A word being consumed this cycle frees the holding register for a new capture.
    assign capture = evt & (~out_valid | out_ready);
    assign drop    = evt & out_valid & ~out_ready;

    // Holding register: loads the source bus on every accepted event.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            sync_bus <= '0;
        else if (capture)
            sync_bus <= unsync_bus;
    end

    // Valid flag and capture strobe; capture takes priority over consume.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid    <= 1'b0;
            enable_pulse <= 1'b0;
        end else begin
            enable_pulse <= capture;
            if (capture)
                out_valid <= 1'b1;
            else if (consume)
                out_valid <= 1'b0;
        end
    end

    // Ack toggle returned to the source on every consumed word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            ack_tgl <= 1'b0;
        else if (consume)
            ack_tgl <= ~ack_tgl;
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

endmodule

// File: rtl/multi_chan_data_sync.sv
// Multi-channel MCP data synchroniser into the CLK domain.
// Instantiates one independent mcp_sync_chan per channel and slices the
// flat buses of the interface into per-channel words.
module multi_chan_data_sync
    import mcp_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 1,
    parameter int EDGE_MODE  = EDGE_LEVEL
) (
    input  logic                   CLK,
    input  logic                   RST,
    multi_chan_data_sync_if.slave  bus_if
);

    // Reject illegal configurations at elaboration.
    if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
        $error("multi_chan_data_sync: NUM_STAGES=%0d outside %0d..%0d",
               NUM_STAGES, MIN_STAGES, MAX_STAGES);
    end
    if (NUM_CH < MIN_CH || NUM_CH > MAX_CH) begin : g_bad_ch
        $error("multi_chan_data_sync: NUM_CH=%0d outside %0d..%0d",
               NUM_CH, MIN_CH, MAX_CH);
    end
    if (EDGE_MODE != EDGE_LEVEL && EDGE_MODE != EDGE_TOGGLE) begin : g_bad_mode
        $error("multi_chan_data_sync: EDGE_MODE=%0d is not LEVEL or TOGGLE", EDGE_MODE);
    end

    logic [NUM_CH*BUS_WIDTH-1:0] sync_bus_w;
    logic [NUM_CH-1:0]           out_valid_w;
    logic [NUM_CH-1:0]           enable_pulse_w;
    logic [NUM_CH-1:0]           ack_tgl_w;
    logic [NUM_CH-1:0]           overflow_w;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        mcp_sync_chan #(
            .BUS_WIDTH  (BUS_WIDTH),
            .NUM_STAGES (NUM_STAGES),
            .EDGE_MODE  (EDGE_MODE)
        ) u_chan (
            .CLK          (CLK),
            .RST          (RST),
            .unsync_bus   (bus_if.unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
            .bus_enable   (bus_if.bus_enable[c]),
            .out_ready    (bus_if.out_ready[c]),
            .ovf_clr      (bus_if.ovf_clr[c]),
            .sync_bus     (sync_bus_w[c*BUS_WIDTH +: BUS_WIDTH]),
            .out_valid    (out_valid_w[c]),
            .enable_pulse (enable_pulse_w[c]),
            .ack_tgl      (ack_tgl_w[c]),
            .overflow     (overflow_w[c])
        );
    end

    assign bus_if.sync_bus     = sync_bus_w;
    assign bus_if.out_valid    = out_valid_w;
    assign bus_if.enable_pulse = enable_pulse_w;
    assign bus_if.ack_tgl      = ack_tgl_w;
    assign bus_if.overflow     = overflow_w;

endmodule

// File: tb/tb_multi_chan_data_sync.sv
// Directed bench for multi_chan_data_sync: a cycle table for the single
// channel LEVEL configuration plus hand sequences for TOGGLE, multi-channel
// and asynchronous reset behaviour.
module tb_multi_chan_data_sync;

    logic CLK;
    logic RST;

    int n_cmp;
    int n_err;

    multi_chan_data_sync_if #(.NUM_CH(1), .BUS_WIDTH(8)) if_a ();
    multi_chan_data_sync_if #(.NUM_CH(1), .BUS_WIDTH(8)) if_t ();
    multi_chan_data_sync_if #(.NUM_CH(4), .BUS_WIDTH(8)) if_m ();

    multi_chan_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .NUM_CH(1), .EDGE_MODE(0)) dut_a (
        .CLK(CLK), .RST(RST), .bus_if(if_a)
    );
    multi_chan_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(3), .NUM_CH(1), .EDGE_MODE(1)) dut_t (
        .CLK(CLK), .RST(RST), .bus_if(if_t)
    );
    multi_chan_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .NUM_CH(4), .EDGE_MODE(0)) dut_m (
        .CLK(CLK), .RST(RST), .bus_if(if_m)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       en;
        logic [7:0] bus;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_bus;
        logic       e_pulse;
        logic       e_ack;
        logic       e_ovf;
    } vec_t;

    vec_t tbl [0:22];

    function automatic vec_t mk(input logic en, input logic [7:0] bus, input logic rdy,
                                input logic clr, input logic v, input logic [7:0] b,
                                input logic p, input logic a, input logic o);
        vec_t r;
        r.en = en; r.bus = bus; r.rdy = rdy; r.clr = clr;
        r.e_valid = v; r.e_bus = b; r.e_pulse = p; r.e_ack = a; r.e_ovf = o;
        return r;
    endfunction

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task step();
        @(posedge CLK);
        #1;
    endtask

    task idle_inputs();
        if_a.unsync_bus = '0; if_a.bus_enable = '0; if_a.out_ready = '0; if_a.ovf_clr = '0;
        if_t.unsync_bus = '0; if_t.bus_enable = '0; if_t.out_ready = '0; if_t.ovf_clr = '0;
        if_m.unsync_bus = '0; if_m.bus_enable = '0; if_m.out_ready = '0; if_m.ovf_clr = '0;
    endtask

    initial begin
        int pulses;
        logic [7:0] b0, b3;

        n_cmp = 0;
        n_err = 0;

        // en, bus, rdy, clr | valid, sync_bus, pulse, ack, ovf (after that edge)
        tbl[0]  = mk(1, 8'hA5, 1, 0,  0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(1, 8'hA5, 1, 0,  0, 8'h00, 0, 0, 0);
        tbl[2]  = mk(1, 8'hA5, 1, 0,  1, 8'hA5, 1, 0, 0);
        tbl[3]  = mk(1, 8'hA5, 1, 0,  0, 8'hA5, 0, 1, 0);
        tbl[4]  = mk(0, 8'h33, 0, 0,  0, 8'hA5, 0, 1, 0);
        tbl[5]  = mk(1, 8'h33, 0, 0,  0, 8'hA5, 0, 1, 0);
        tbl[6]  = mk(1, 8'h33, 0, 0,  0, 8'hA5, 0, 1, 0);
        tbl[7]  = mk(1, 8'h33, 0, 0,  1, 8'h33, 1, 1, 0);
        tbl[8]  = mk(0, 8'h33, 0, 0,  1, 8'h33, 0, 1, 0);
        tbl[9]  = mk(1, 8'h44, 0, 0,  1, 8'h33, 0, 1, 0);
        tbl[10] = mk(1, 8'h44, 0, 0,  1, 8'h33, 0, 1, 0);
        tbl[11] = mk(1, 8'h44, 0, 0,  1, 8'h33, 0, 1, 1);
        tbl[12] = mk(1, 8'h44, 0, 1,  1, 8'h33, 0, 1, 0);
        tbl[13] = mk(1, 8'h44, 1, 0,  0, 8'h33, 0, 0, 0);
        tbl[14] = mk(0, 8'h55, 0, 0,  0, 8'h33, 0, 0, 0);
        tbl[15] = mk(1, 8'h55, 0, 0,  0, 8'h33, 0, 0, 0);
        tbl[16] = mk(1, 8'h55, 0, 0,  0, 8'h33, 0, 0, 0);
        tbl[17] = mk(1, 8'h55, 0, 0,  1, 8'h55, 1, 0, 0);
        tbl[18] = mk(0, 8'h55, 0, 0,  1, 8'h55, 0, 0, 0);
        tbl[19] = mk(1, 8'h66, 0, 0,  1, 8'h55, 0, 0, 0);
        tbl[20] = mk(1, 8'h66, 0, 0,  1, 8'h55, 0, 0, 0);
        tbl[21] = mk(1, 8'h66, 1, 0,  1, 8'h66, 1, 1, 0);
        tbl[22] = mk(1, 8'h66, 0, 0,  1, 8'h66, 0, 1, 0);

        // Reset state
        idle_inputs();
        RST = 1'b1;
        #2 RST = 1'b0;
        #1;
        chk("rst_a_bus",   32'(if_a.sync_bus),     32'h0);
        chk("rst_a_valid", 32'(if_a.out_valid),    32'h0);
        chk("rst_a_pulse", 32'(if_a.enable_pulse), 32'h0);
        chk("rst_a_ack",   32'(if_a.ack_tgl),      32'h0);
        chk("rst_a_ovf",   32'(if_a.overflow),     32'h0);
        chk("rst_m_bus",   32'(if_m.sync_bus),     32'h0);
        step();
        step();
        @(negedge CLK);
        RST = 1'b1;
        step();
        step();

        // Single channel LEVEL table: capture latency, backpressure, overflow, simultaneous
        for (int i = 0; i <= 22; i++) begin
            if_a.bus_enable = tbl[i].en;
            if_a.unsync_bus = tbl[i].bus;
            if_a.out_ready  = tbl[i].rdy;
            if_a.ovf_clr    = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(if_a.out_valid),    32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_bus", i),   32'(if_a.sync_bus),     32'(tbl[i].e_bus));
            chk($sformatf("tbl%0d_pulse", i), 32'(if_a.enable_pulse), 32'(tbl[i].e_pulse));
            chk($sformatf("tbl%0d_ack", i),   32'(if_a.ack_tgl),      32'(tbl[i].e_ack));
            chk($sformatf("tbl%0d_ovf", i),   32'(if_a.overflow),     32'(tbl[i].e_ovf));
        end
        if_a.out_ready = 1'b0;
        if_a.ovf_clr   = 1'b0;

        // TOGGLE, NS=3: 0->1 with 8'h11, then 1->0 with 8'h22
        if_t.out_ready = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            if_t.bus_enable = (e < 5) ? 1'b1 : 1'b0;
            if_t.unsync_bus = (e < 5) ? 8'h11 : 8'h22;
            step();
            case (e)
                3: begin
                    chk("tgl_cap1_valid", 32'(if_t.out_valid),    32'h1);
                    chk("tgl_cap1_bus",   32'(if_t.sync_bus),     32'h11);
                    chk("tgl_cap1_pulse", 32'(if_t.enable_pulse), 32'h1);
                end
                4: begin
                    chk("tgl_ack1",       32'(if_t.ack_tgl),      32'h1);
                    chk("tgl_pulse_off",  32'(if_t.enable_pulse), 32'h0);
                end
                8: begin
                    chk("tgl_cap2_valid", 32'(if_t.out_valid),    32'h1);
                    chk("tgl_cap2_bus",   32'(if_t.sync_bus),     32'h22);
                    chk("tgl_cap2_pulse", 32'(if_t.enable_pulse), 32'h1);
                end
                9: begin
                    chk("tgl_ack2",       32'(if_t.ack_tgl),      32'h0);
                    chk("tgl_end_valid",  32'(if_t.out_valid),    32'h0);
                end
                default: chk($sformatf("tgl_e%0d_valid", e), 32'(if_t.out_valid), 32'h0);
            endcase
        end
        if_t.out_ready = 1'b0;

        // Four channels: staggered events on ch0 and ch3, ch3 backpressured
        if_m.out_ready = 4'b0111;
        for (int e = 0; e <= 8; e++) begin
            if_m.bus_enable[0] = (e == 4) ? 1'b0 : 1'b1;
            if_m.bus_enable[3] = (e == 0 || e == 4) ? 1'b0 : 1'b1;
            b0 = (e < 5) ? 8'h10 : 8'h11;
            b3 = (e < 5) ? 8'h30 : 8'h31;
            if_m.unsync_bus = {b3, 8'h00, 8'h00, b0};
            step();
            case (e)
                2: begin
                    chk("m2_valid", 32'(if_m.out_valid),    32'h1);
                    chk("m2_pulse", 32'(if_m.enable_pulse), 32'h1);
                    chk("m2_bus",   if_m.sync_bus,          32'h0000_0010);
                end
                3: begin
                    chk("m3_valid", 32'(if_m.out_valid),    32'h8);
                    chk("m3_pulse", 32'(if_m.enable_pulse), 32'h8);
                    chk("m3_bus",   if_m.sync_bus,          32'h3000_0010);
                    chk("m3_ack",   32'(if_m.ack_tgl),      32'h1);
                end
                7: begin
                    chk("m7_valid", 32'(if_m.out_valid),    32'h9);
                    chk("m7_pulse", 32'(if_m.enable_pulse), 32'h1);
                    chk("m7_bus",   if_m.sync_bus,          32'h3000_0011);
                    chk("m7_ovf",   32'(if_m.overflow),     32'h8);
                    chk("m7_ack",   32'(if_m.ack_tgl),      32'h1);
                end
                8: begin
                    chk("m8_valid", 32'(if_m.out_valid),    32'h8);
                    chk("m8_ack",   32'(if_m.ack_tgl),      32'h0);
                    chk("m8_ovf",   32'(if_m.overflow),     32'h8);
                    chk("m8_pulse", 32'(if_m.enable_pulse), 32'h0);
                end
                default: chk($sformatf("m%0d_ovf", e), 32'(if_m.overflow), 32'h0);
            endcase
        end

        // Async reset while dut_a holds a word and its chain is mid-transition
        if_a.bus_enable = 1'b0;
        step();
        #2 RST = 1'b0;
        #1;
        chk("arst_a_bus",   32'(if_a.sync_bus),     32'h0);
        chk("arst_a_valid", 32'(if_a.out_valid),    32'h0);
        chk("arst_a_pulse", 32'(if_a.enable_pulse), 32'h0);
        chk("arst_a_ack",   32'(if_a.ack_tgl),      32'h0);
        chk("arst_a_ovf",   32'(if_a.overflow),     32'h0);
        chk("arst_m_ovf",   32'(if_m.overflow),     32'h0);
        idle_inputs();
        if_a.bus_enable = 1'b1;
        if_a.unsync_bus = 8'h77;
        @(negedge CLK);
        RST = 1'b1;
        pulses = 0;
        for (int k = 0; k <= 6; k++) begin
            step();
            if (if_a.enable_pulse === 1'b1) pulses++;
            if (k < 2)
                chk($sformatf("arst_k%0d_valid", k), 32'(if_a.out_valid), 32'h0);
            if (k == 2) begin
                chk("arst_cap_valid", 32'(if_a.out_valid),    32'h1);
                chk("arst_cap_bus",   32'(if_a.sync_bus),     32'h77);
                chk("arst_cap_pulse", 32'(if_a.enable_pulse), 32'h1);
            end
        end
        chk("arst_pulse_count", 32'(pulses),           32'h1);
        chk("arst_end_ovf",     32'(if_a.overflow),    32'h0);
        chk("arst_end_valid",   32'(if_a.out_valid),   32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
